// File: rtl/sequence_generator_pkg.sv
// Shared types for the serial pattern transmitter.
// FSM state encoding and default widths.
package sequence_generator_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_GAP_W = 4;

endpackage

// File: rtl/sequence_generator_bit_down_counter.sv
// Loadable down-counter with zero flag.
// Saturates at zero; load has priority over decrement.
module bit_down_counter
  import sequence_generator_pkg::*;
#(
  parameter int W = DEF_LEN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: MSB-first frames on X,
// repeated with programmable idle gaps.
module sequence_generator
  import sequence_generator_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             X,
  output logic             x_valid,
  output logic             frame_end,
  output logic             busy,
  output logic             done
);

  localparam logic [LEN_W-1:0] PAT_L = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] l_q;
  logic [GAP_W-1:0] gap_q;

  logic [LEN_W-1:0] bit_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             bit_zero;
  logic             rep_zero;
  logic             gap_zero;

  logic             accept;
  logic             last_bit;
  logic [LEN_W-1:0] eff_l;
  logic [PAT_W-1:0] in_sh;
  logic [PAT_W-1:0] nxt_sh;
  logic [PAT_W-1:0] msb_sh;

  logic             bit_load;
  logic [LEN_W-1:0] bit_val;
  logic             bit_dec;
  logic             rep_load;
  logic [CNT_W-1:0] rep_val;
  logic             rep_dec;
  logic             gap_load;
  logic [GAP_W-1:0] gap_val;
  logic             gap_dec;

  always_comb begin
    accept   = start && (state == S_IDLE || state == S_DONE);
    last_bit = (state == S_SHIFT) && bit_zero;
    eff_l    = (len == '0 || len > PAT_L) ? PAT_L : len;
    in_sh    = pattern >> (eff_l - ONE_L);
    nxt_sh   = pat_q >> (bit_cnt - ONE_L);
    msb_sh   = pat_q >> (l_q - ONE_L);

    bit_load = accept
             || (last_bit && !rep_zero && gap_q == '0)
             || (state == S_GAP && gap_zero);
    bit_val  = accept ? eff_l - ONE_L : l_q - ONE_L;
    bit_dec  = (state == S_SHIFT) && !bit_zero;

    rep_load = accept;
    rep_val  = (reps == '0) ? '0 : reps - CNT_W'(1);
    rep_dec  = last_bit && !rep_zero;

    gap_load = last_bit && !rep_zero && gap_q != '0;
    gap_val  = gap_q - GAP_W'(1);
    gap_dec  = (state == S_GAP) && !gap_zero;
  end

  bit_down_counter #(.W(LEN_W)) u_bit (
    .clk  (clk),
    .rst  (rst),
    .load (bit_load),
    .val  (bit_val),
    .dec  (bit_dec),
    .cnt  (bit_cnt),
    .zero (bit_zero)
  );

  bit_down_counter #(.W(CNT_W)) u_rep (
    .clk  (clk),
    .rst  (rst),
    .load (rep_load),
    .val  (rep_val),
    .dec  (rep_dec),
    .cnt  (rep_cnt),
    .zero (rep_zero)
  );

  bit_down_counter #(.W(GAP_W)) u_gap (
    .clk  (clk),
    .rst  (rst),
    .load (gap_load),
    .val  (gap_val),
    .dec  (gap_dec),
    .cnt  (gap_cnt),
    .zero (gap_zero)
  );

  // Only the zero flags of the repeat and gap counters steer the FSM.
  logic unused_cnt;
  assign unused_cnt = ^{rep_cnt, gap_cnt};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pat_q     <= '0;
      l_q       <= '0;
      gap_q     <= '0;
      X         <= 1'b0;
      x_valid   <= 1'b0;
      frame_end <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (accept) begin
            state     <= S_SHIFT;
            pat_q     <= pattern;
            l_q       <= eff_l;
            gap_q     <= gap;
            X         <= in_sh[0];
            x_valid   <= 1'b1;
            frame_end <= (eff_l == ONE_L);
            busy      <= 1'b1;
          end else begin
            state     <= S_IDLE;
            X         <= 1'b0;
            x_valid   <= 1'b0;
            frame_end <= 1'b0;
            busy      <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (!bit_zero) begin
            X         <= nxt_sh[0];
            frame_end <= (bit_cnt == ONE_L);
          end else if (rep_zero) begin
            state     <= S_DONE;
            X         <= 1'b0;
            x_valid   <= 1'b0;
            frame_end <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (gap_q == '0) begin
            X         <= msb_sh[0];
            frame_end <= (l_q == ONE_L);
          end else begin
            state     <= S_GAP;
            X         <= 1'b0;
            x_valid   <= 1'b0;
            frame_end <= 1'b0;
          end
        end
        S_GAP: begin
          if (gap_zero) begin
            state     <= S_SHIFT;
            X         <= msb_sh[0];
            x_valid   <= 1'b1;
            frame_end <= (l_q == ONE_L);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
